// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: per-register advance/hold/flush, PC redirect, hazard counters.
// Zero-latency combinational controls; data-memory wait freezes the whole pipe, load-use holds PC and IF/ID.
`timescale 1ns/1ps

module hazard_ctrl #(
    parameter int LOAD_USE_BUBBLES = 1,
    parameter int MEM_TIMEOUT      = 255,
    parameter int CNT_W            = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [31:0]      i_ID_inst,
    input  logic [31:0]      i_EX_inst,
    input  logic             i_EX_mem_rden,
    input  logic             i_EX_rd_wren,
    input  logic             i_EX_br_valid,
    input  logic             i_EX_br_mispredict,
    input  logic             i_MEM_req,
    input  logic             i_MEM_ack,
    output logic             o_pc_en,
    output logic             o_pc_redirect,
    output logic             o_IF_ID_en,
    output logic             o_ID_EX_en,
    output logic             o_EX_MEM_en,
    output logic             o_IF_ID_flush,
    output logic             o_ID_EX_flush,
    output logic             o_MEM_WB_flush,
    output logic             o_mem_timeout,
    output logic [CNT_W-1:0] o_stall_cycles,
    output logic [CNT_W-1:0] o_flush_count
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LD_STALL = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nxt;
    logic              timeout_q;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    logic [6:0] id_opcode;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic [4:0] ex_rd;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       mem_wait;
    logic       mispred;
    logic       load_use;
    logic       bubble;
    logic       unused_bits;

    assign id_opcode = i_ID_inst[6:0];
    assign id_rs1    = i_ID_inst[19:15];
    assign id_rs2    = i_ID_inst[24:20];
    assign ex_rd     = i_EX_inst[11:7];

    assign unused_bits = ^{i_ID_inst[31:25], i_ID_inst[14:7], i_EX_inst[31:12], i_EX_inst[6:0]};

    assign uses_rs1 = !((id_opcode == OP_LUI) || (id_opcode == OP_AUIPC) || (id_opcode == OP_JAL));
    assign uses_rs2 = (id_opcode == OP_RTYPE) || (id_opcode == OP_BRANCH) || (id_opcode == OP_STORE);

    assign mem_wait = i_MEM_req & ~i_MEM_ack;
    assign mispred  = i_EX_br_valid & i_EX_br_mispredict;
    assign load_use = i_EX_mem_rden & i_EX_rd_wren & (ex_rd != 5'd0) &
                      ((uses_rs1 & (id_rs1 == ex_rd)) | (uses_rs2 & (id_rs2 == ex_rd)));

    // The second load-use bubble is forced without looking at ID/EX again.
    assign bubble = (state == ST_LD_STALL) | load_use;

    // Wait counter restarts at 1 on the first frozen cycle and saturates at the timeout.
    always_comb begin
        wait_nxt = WAIT_W'(1);
        if (state == ST_MEM_WAIT) begin
            if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
                wait_nxt = wait_cnt;
            end else begin
                wait_nxt = wait_cnt + WAIT_W'(1);
            end
        end
    end

    always_comb begin
        o_pc_en        = 1'b1;
        o_pc_redirect  = 1'b0;
        o_IF_ID_en     = 1'b1;
        o_ID_EX_en     = 1'b1;
        o_EX_MEM_en    = 1'b1;
        o_IF_ID_flush  = 1'b0;
        o_ID_EX_flush  = 1'b0;
        o_MEM_WB_flush = 1'b0;
        if (i_reset) begin
            o_pc_en        = 1'b0;
            o_IF_ID_en     = 1'b0;
            o_ID_EX_en     = 1'b0;
            o_EX_MEM_en    = 1'b0;
            o_IF_ID_flush  = 1'b1;
            o_ID_EX_flush  = 1'b1;
            o_MEM_WB_flush = 1'b1;
        end else if (mem_wait) begin
            o_pc_en        = 1'b0;
            o_IF_ID_en     = 1'b0;
            o_ID_EX_en     = 1'b0;
            o_EX_MEM_en    = 1'b0;
            o_MEM_WB_flush = 1'b1;
        end else if (mispred) begin
            o_pc_redirect  = 1'b1;
            o_IF_ID_flush  = 1'b1;
            o_ID_EX_flush  = 1'b1;
        end else if (bubble) begin
            o_pc_en        = 1'b0;
            o_IF_ID_en     = 1'b0;
            o_ID_EX_flush  = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= ST_RUN;
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (mem_wait) begin
                state    <= ST_MEM_WAIT;
                wait_cnt <= wait_nxt;
                if (wait_nxt == WAIT_W'(MEM_TIMEOUT)) begin
                    timeout_q <= 1'b1;
                end
            end else begin
                wait_cnt <= '0;
                if (mispred) begin
                    state <= ST_RUN;
                end else if ((state != ST_LD_STALL) && load_use && (LOAD_USE_BUBBLES == 2)) begin
                    state <= ST_LD_STALL;
                end else begin
                    state <= ST_RUN;
                end
            end

            if (!o_pc_en && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (!mem_wait && mispred && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

    assign o_mem_timeout  = timeout_q;
    assign o_stall_cycles = stall_cnt;
    assign o_flush_count  = flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (1 and 2 load-use bubbles) checked against a bubble-count model via scoreboard queues.
`timescale 1ns/1ps

module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] id_inst = 32'h13;
    logic [31:0] ex_inst = 32'h13;
    logic        ex_mem_rden = 1'b0;
    logic        ex_rd_wren = 1'b0;
    logic        br_valid = 1'b0;
    logic        br_mispred = 1'b0;
    logic        mem_req = 1'b0;
    logic        mem_ack = 1'b0;

    logic [1:0]  pc_en, redirect, ifid_en, idex_en, exmem_en, ifid_fl, idex_fl, memwb_fl, tmo;
    logic [7:0]  stall0, flush0;
    logic [15:0] stall1, flush1;

    always #5 clk = ~clk;

    hazard_ctrl #(.LOAD_USE_BUBBLES(1), .MEM_TIMEOUT(4), .CNT_W(8)) u_dut0 (
        .i_clk(clk), .i_reset(rst), .i_ID_inst(id_inst), .i_EX_inst(ex_inst),
        .i_EX_mem_rden(ex_mem_rden), .i_EX_rd_wren(ex_rd_wren),
        .i_EX_br_valid(br_valid), .i_EX_br_mispredict(br_mispred),
        .i_MEM_req(mem_req), .i_MEM_ack(mem_ack),
        .o_pc_en(pc_en[0]), .o_pc_redirect(redirect[0]), .o_IF_ID_en(ifid_en[0]),
        .o_ID_EX_en(idex_en[0]), .o_EX_MEM_en(exmem_en[0]), .o_IF_ID_flush(ifid_fl[0]),
        .o_ID_EX_flush(idex_fl[0]), .o_MEM_WB_flush(memwb_fl[0]), .o_mem_timeout(tmo[0]),
        .o_stall_cycles(stall0), .o_flush_count(flush0)
    );

    hazard_ctrl #(.LOAD_USE_BUBBLES(2), .MEM_TIMEOUT(6), .CNT_W(16)) u_dut1 (
        .i_clk(clk), .i_reset(rst), .i_ID_inst(id_inst), .i_EX_inst(ex_inst),
        .i_EX_mem_rden(ex_mem_rden), .i_EX_rd_wren(ex_rd_wren),
        .i_EX_br_valid(br_valid), .i_EX_br_mispredict(br_mispred),
        .i_MEM_req(mem_req), .i_MEM_ack(mem_ack),
        .o_pc_en(pc_en[1]), .o_pc_redirect(redirect[1]), .o_IF_ID_en(ifid_en[1]),
        .o_ID_EX_en(idex_en[1]), .o_EX_MEM_en(exmem_en[1]), .o_IF_ID_flush(ifid_fl[1]),
        .o_ID_EX_flush(idex_fl[1]), .o_MEM_WB_flush(memwb_fl[1]), .o_mem_timeout(tmo[1]),
        .o_stall_cycles(stall1), .o_flush_count(flush1)
    );

    // flags = {pc_en, redirect, IF_ID_en, ID_EX_en, EX_MEM_en, IF_ID_flush, ID_EX_flush, MEM_WB_flush}
    typedef struct {
        logic [7:0] flags;
        bit         known;
        bit         tmo;
        longint     stall;
        longint     flush;
    } exp_t;

    exp_t   q0[$];
    exp_t   q1[$];
    int     n_checks = 0;
    int     n_fail = 0;

    int     bub[2]  = '{1, 2};
    int     tlim[2] = '{4, 6};
    longint cmax[2] = '{255, 65535};
    int     extra[2];
    int     wlen[2];
    bit     to_flag[2];
    longint stc[2];
    longint flc[2];
    bit     known[2] = '{0, 0};

    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] LW5     = {12'd0, 5'd1, 3'b010, 5'd5, 7'b0000011};
    localparam logic [31:0] LW0     = {12'd0, 5'd1, 3'b010, 5'd0, 7'b0000011};
    localparam logic [31:0] ADD_DEP = {7'd0, 5'd2, 5'd5, 3'd0, 5'd6, 7'b0110011};
    localparam logic [31:0] ADD_X0  = {7'd0, 5'd0, 5'd0, 3'd0, 5'd6, 7'b0110011};
    localparam logic [31:0] LUI5    = {20'h00028, 5'd5, 7'b0110111};  // rs1 field happens to be 5
    localparam logic [31:0] ADDI    = {12'd5, 5'd7, 3'd0, 5'd6, 7'b0010011};

    function automatic bit reads_rs1(input logic [6:0] op);
        case (op)
            7'b0110111, 7'b0010111, 7'b1101111: return 1'b0;
            default:                            return 1'b1;
        endcase
    endfunction

    function automatic bit reads_rs2(input logic [6:0] op);
        case (op)
            7'b0110011, 7'b1100011, 7'b0100011: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    function automatic longint sat_inc(input longint v, input longint m);
        return (v >= m) ? m : v + 1;
    endfunction

    task automatic model(input int k, output exp_t e);
        bit mw, mp, lu;
        bit pc, rd, ie, de, xe, ifl, dfl, wfl;
        e.known = known[k];
        e.tmo   = to_flag[k];
        e.stall = stc[k];
        e.flush = flc[k];
        if (rst) begin
            e.flags    = 8'b0000_0111;
            extra[k]   = 0;
            wlen[k]    = 0;
            to_flag[k] = 0;
            stc[k]     = 0;
            flc[k]     = 0;
            known[k]   = 1;
            return;
        end
        mw = mem_req && !mem_ack;
        mp = br_valid && br_mispred;
        lu = ex_mem_rden && ex_rd_wren && (ex_inst[11:7] != 0) &&
             ((reads_rs1(id_inst[6:0]) && id_inst[19:15] == ex_inst[11:7]) ||
              (reads_rs2(id_inst[6:0]) && id_inst[24:20] == ex_inst[11:7]));
        {pc, rd, ie, de, xe, ifl, dfl, wfl} = 8'b1011_1000;
        if (mw) begin
            {pc, ie, de, xe, wfl} = 5'b00001;
            wlen[k]  = wlen[k] + 1;
            if (wlen[k] >= tlim[k]) to_flag[k] = 1;
            extra[k] = 0;
        end else begin
            wlen[k] = 0;
            if (mp) begin
                {rd, ifl, dfl} = 3'b111;
                extra[k] = 0;
                flc[k]   = sat_inc(flc[k], cmax[k]);
            end else if (extra[k] > 0) begin
                {pc, ie, dfl} = 3'b001;
                extra[k] = extra[k] - 1;
            end else if (lu) begin
                {pc, ie, dfl} = 3'b001;
                extra[k] = bub[k] - 1;
            end
        end
        if (!pc) stc[k] = sat_inc(stc[k], cmax[k]);
        e.flags = {pc, rd, ie, de, xe, ifl, dfl, wfl};
    endtask

    task automatic step(input bit r, input logic [31:0] idi, input logic [31:0] exi,
                        input bit rden, input bit wren, input bit bv, input bit bm,
                        input bit req, input bit ack);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; id_inst = idi; ex_inst = exi; ex_mem_rden = rden; ex_rd_wren = wren;
        br_valid = bv; br_mispred = bm; mem_req = req; mem_ack = ack;
        model(0, e);
        q0.push_back(e);
        model(1, e);
        q1.push_back(e);
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] act_flags(input int k);
        return {pc_en[k], redirect[k], ifid_en[k], idex_en[k], exmem_en[k], ifid_fl[k], idex_fl[k], memwb_fl[k]};
    endfunction

    task automatic compare(input int k, input exp_t e);
        longint st, fl;
        st = (k == 0) ? longint'(stall0) : longint'(stall1);
        fl = (k == 0) ? longint'(flush0) : longint'(flush1);
        n_checks++;
        if (act_flags(k) !== e.flags) begin
            n_fail++;
            $display("FAIL sb%0d_flags: got %b expected %b at %0t", k, act_flags(k), e.flags, $time);
        end
        if (e.known) begin
            chk($sformatf("sb%0d_timeout", k), longint'(tmo[k]), longint'(e.tmo));
            chk($sformatf("sb%0d_stall_cycles", k), st, e.stall);
            chk($sformatf("sb%0d_flush_count", k), fl, e.flush);
        end
    endtask

    // Monitor: outputs are combinational, so each queued expectation belongs to the current cycle.
    always @(negedge clk) begin
        if (q0.size() > 0) compare(0, q0.pop_front());
        if (q1.size() > 0) compare(1, q1.pop_front());
    end

    function automatic logic [31:0] rnd_inst();
        logic [6:0] ops[9];
        ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};
        return {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                3'($urandom), 5'($urandom_range(0, 3)), ops[$urandom_range(0, 8)]};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int burst;
        bit r, req, ack;
        step(1, NOP, NOP, 0, 0, 0, 0, 0, 0);
        step(1, NOP, NOP, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("rst_pc_en", pc_en[0], 0);
        chk("rst_memwb_flush", memwb_fl[0], 1);

        // load-use on rs1
        step(0, ADD_DEP, LW5, 1, 1, 0, 0, 0, 0);
        @(negedge clk);
        chk("lu_pc_en", pc_en[0], 0);
        chk("lu_ifid_en", ifid_en[0], 0);
        chk("lu_idex_flush", idex_fl[0], 1);
        step(0, ADD_DEP, NOP, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("lu_release_pc_en", pc_en[0], 1);
        chk("lu_stall_cycles", stall0, 1);
        chk("lu2_second_bubble", pc_en[1], 0);
        step(0, NOP, NOP, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("lu2_stall_cycles", stall1, 2);
        chk("lu2_back_to_run", pc_en[1], 1);

        // no false stalls
        step(0, ADD_X0, LW0, 1, 1, 0, 0, 0, 0);
        @(negedge clk);
        chk("nfs_rd_x0", pc_en[0], 1);
        step(0, LUI5, LW5, 1, 1, 0, 0, 0, 0);
        @(negedge clk);
        chk("nfs_lui", pc_en[0], 1);
        step(0, ADDI, LW5, 1, 1, 0, 0, 0, 0);
        @(negedge clk);
        chk("nfs_itype_rs2", pc_en[0], 1);

        // mispredict beats load-use
        step(1, NOP, NOP, 0, 0, 0, 0, 0, 0);
        step(0, ADD_DEP, LW5, 1, 1, 1, 1, 0, 0);
        @(negedge clk);
        chk("mp_redirect", redirect[0], 1);
        chk("mp_pc_en", pc_en[0], 1);
        chk("mp_ifid_flush", ifid_fl[0], 1);
        chk("mp_idex_flush", idex_fl[0], 1);
        step(0, NOP, NOP, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("mp_flush_count", flush0, 1);
        chk("mp_no_stall", stall0, 0);

        // memory wait holds off a pending mispredict
        step(1, NOP, NOP, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, NOP, NOP, 0, 0, 1, 1, 1, 0);
            @(negedge clk);
            chk("mw_pc_en", pc_en[0], 0);
            chk("mw_memwb_flush", memwb_fl[0], 1);
            chk("mw_no_redirect", redirect[0], 0);
        end
        step(0, NOP, NOP, 0, 0, 1, 1, 1, 1);
        @(negedge clk);
        chk("mw_ack_redirect", redirect[0], 1);
        step(0, NOP, NOP, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("mw_stall_cycles", stall0, 3);
        chk("mw_flush_count", flush0, 1);

        // timeout: dut0 limit 4, dut1 limit 6
        step(1, NOP, NOP, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 6; i++) begin
            step(0, NOP, NOP, 0, 0, 0, 0, 1, 0);
            @(negedge clk);
            chk($sformatf("to0_cycle%0d", i), tmo[0], (i >= 5) ? 1 : 0);
            chk($sformatf("to1_cycle%0d", i), tmo[1], 0);
        end
        step(0, NOP, NOP, 0, 0, 0, 0, 1, 1);
        @(negedge clk);
        chk("to0_after_ack", tmo[0], 1);
        chk("to1_after_ack", tmo[1], 1);
        step(0, NOP, NOP, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("to0_sticky", tmo[0], 1);
        step(1, NOP, NOP, 0, 0, 0, 0, 0, 0);
        step(0, NOP, NOP, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("to0_cleared", tmo[0], 0);

        // reset in the second load-use bubble
        step(0, ADD_DEP, LW5, 1, 1, 0, 0, 0, 0);
        @(negedge clk);
        chk("lr_first_bubble", pc_en[1], 0);
        step(1, ADD_DEP, NOP, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("lr_rst_pc_en", pc_en[1], 0);
        chk("lr_rst_exmem_en", exmem_en[1], 0);
        chk("lr_rst_ifid_flush", ifid_fl[1], 1);
        step(0, ADD_DEP, NOP, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("lr_run_pc_en", pc_en[1], 1);
        chk("lr_stall_zero", stall1, 0);
        chk("lr_flush_zero", flush1, 0);

        // randomized traffic
        burst = 0;
        for (int c = 0; c < 4000; c++) begin
            r = ($urandom_range(0, 999) == 0);
            if (burst > 0) begin
                req = 1; ack = (burst == 1); burst--;
            end else begin
                req = ($urandom_range(0, 3) == 0);
                ack = ($urandom_range(0, 1) == 0);
                if ($urandom_range(0, 14) == 0) burst = $urandom_range(1, 9);
            end
            step(r, rnd_inst(), rnd_inst(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), req, ack);
        end
        step(0, NOP, NOP, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d/%0d pending expected 0/0", q0.size(), q1.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the 5-stage RV32I core with always-taken branch prediction. It decides, every cycle, whether each pipeline register advances, holds or is flushed. It combines three hazard sources: data-memory wait, branch mispredict resolved in EX, and load-use. Operand forwarding is handled by the separate forwarding unit; this block only produces stalls, bubbles, PC redirect and hazard performance counters.

## Interface
- `LOAD_USE_BUBBLES`, default 1: bubbles inserted per load-use hazard; legal values 1..2.
- `MEM_TIMEOUT`, default 255: consecutive data-memory wait cycles before `o_mem_timeout` is set.
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `i_clk`  in  1  clock. Single clock domain.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_ID_inst`  in  32  instruction in the ID stage.
- `i_EX_inst`  in  32  instruction in the EX stage.
- `i_EX_mem_rden`  in  1  EX instruction is a load.
- `i_EX_rd_wren`  in  1  EX instruction writes rd.
- `i_EX_br_valid`  in  1  EX holds a resolved branch or jump.
- `i_EX_br_mispredict`  in  1  resolved outcome differs from the always-taken prediction; qualified by `i_EX_br_valid`.
- `i_MEM_req`  in  1  MEM stage issues a load or store this cycle.
- `i_MEM_ack`  in  1  data memory completes the MEM request this cycle.
- `o_pc_en`  out  1  PC register update enable.
- `o_pc_redirect`  out  1  PC takes the corrected target from EX.
- `o_IF_ID_en`, `o_ID_EX_en`, `o_EX_MEM_en`  out  1 each  pipeline register enables.
- `o_IF_ID_flush`, `o_ID_EX_flush`, `o_MEM_WB_flush`  out  1 each  load NOP or bubble into that register.
- `o_mem_timeout`  out  1  sticky error flag.
- `o_stall_cycles`  out  `CNT_W`  count of cycles in which `o_pc_en` = 0, excluding reset.
- `o_flush_count`  out  `CNT_W`  count of mispredicts.

## Operation
Field extraction: ID rs1 = [19:15], ID rs2 = [24:20], EX rd = [11:7]. ID opcode is [6:0].
- Uses rs1: every opcode except LUI (0110111), AUIPC (0010111) and JAL (1101111).
- Uses rs2: only R-type (0110011), branch (1100011) and store (0100011).

Hazard conditions:
- `mem_wait` = `i_MEM_req` & !`i_MEM_ack`.
- `mispred` = `i_EX_br_valid` & `i_EX_br_mispredict`.
- `load_use` = `i_EX_mem_rden` & `i_EX_rd_wren` & (rd ≠ 0) & ((uses rs1 & rs1 == rd) | (uses rs2 & rs2 == rd)).

Priority, highest first:
1. **`mem_wait`** freezes the whole pipe.
   - `o_pc_en`, `o_IF_ID_en`, `o_ID_EX_en`, `o_EX_MEM_en` = 0.
   - `o_MEM_WB_flush` = 1.
   - Mispredict and load-use are deferred. EX is frozen, so both are re-evaluated on the release cycle.
2. **`mispred`** redirects and kills the wrong-path instructions.
   - `o_pc_redirect` = 1, `o_IF_ID_flush` = 1, `o_ID_EX_flush` = 1.
   - All enables = 1.
   - The bubble counter is cleared and the FSM returns to RUN.
3. **`load_use`** (only in RUN) inserts a bubble.
   - `o_pc_en` = 0, `o_IF_ID_en` = 0, `o_ID_EX_flush` = 1.
4. **Otherwise:** all enables = 1 and all flushes = 0.

State machine:
- **RUN**
  - `mem_wait` → MEM_WAIT; the wait counter loads 1.
  - `load_use` with `LOAD_USE_BUBBLES` = 2 → LD_STALL.
  - Otherwise stay in RUN.
- **LD_STALL**
  - Inserts one more bubble with the same outputs as `load_use`, regardless of the ID/EX contents, then → RUN.
  - If `mem_wait` or `mispred` occurs in this state, it takes priority: `mem_wait` → MEM_WAIT; `mispred` → RUN.
- **MEM_WAIT**
  - Wait counter increments while `mem_wait` holds, saturating at `MEM_TIMEOUT`.
  - When the counter reaches `MEM_TIMEOUT`, `o_mem_timeout` is set (sticky until reset). The pipe stays frozen.
  - The cycle with `i_MEM_ack` = 1 releases the freeze and the FSM → RUN.
  - Rules 2–4 apply in that same release cycle.

Counters:
- Both counters saturate at all-ones and never wrap.
- `o_stall_cycles` increments in any non-reset cycle with `o_pc_en` = 0.
- `o_flush_count` increments in each cycle where `mispred` is acted on.

## Timing
- All hazard outputs are combinational from the inputs and the current FSM state. There is no added latency.
- The FSM, wait counter, `o_mem_timeout` and both counters update on the rising `i_clk` edge.
- Reset: while `i_reset` = 1, the outputs are forced regardless of other inputs:
  - `o_pc_en`, all `*_en` = 0.
  - `o_IF_ID_flush`, `o_ID_EX_flush`, `o_MEM_WB_flush` = 1.
  - `o_pc_redirect` = 0.
- At the first edge with `i_reset` high: state becomes RUN, counters become 0 and `o_mem_timeout` becomes 0.
- Reset asserted mid-stall or mid-wait aborts the stall or wait with no residue.
- A load-use hazard with `LOAD_USE_BUBBLES` = 1 costs exactly 1 cycle. The dependent instruction re-evaluates next cycle against the new EX contents (a bubble), so no repeat stall occurs.
- A mispredict costs 2 cycles: the instructions in IF/ID and ID/EX are killed.

## Test plan
- **Load-use, rs1:** EX = `lw x5,0(x1)`, ID = `add x6,x5,x2` → one cycle with `o_pc_en` = 0, `o_IF_ID_en` = 0, `o_ID_EX_flush` = 1; next cycle all enables = 1. `o_stall_cycles` = 1.
- **No false stall:**
  - EX = `lw x0,0(x1)`, ID = `add x6,x0,x0` → no stall (rd is x0).
  - EX = `lw x5,0(x1)`, ID = `lui x5,1` → no stall (LUI uses no rs).
  - EX = `lw x5,0(x1)`, ID = `addi x6,x7,5`, where rs2 field [24:20] = 5 → no stall (I-type does not use rs2).
- **Mispredict vs. load-use in the same cycle:** mispredict asserted while a load-use condition is also true → `o_pc_redirect`, `o_IF_ID_flush`, `o_ID_EX_flush` = 1; `o_pc_en` = 1; `o_flush_count` = 1; no stall.
- **Memory wait with deferred mispredict:**
  - `i_MEM_req` = 1, `i_MEM_ack` = 0 for 3 cycles, with a mispredict pending in EX → pipe frozen and `o_MEM_WB_flush` = 1 for 3 cycles.
  - On the ack cycle → redirect fires once.
  - `o_stall_cycles` = 3.
- **Timeout:** `MEM_TIMEOUT` = 4 and ack withheld for 6 cycles → `o_mem_timeout` = 1 after the 4th wait cycle, remains 1 after ack, cleared only by `i_reset`.
- **`LOAD_USE_BUBBLES` = 2 with reset:**
  - Load-use → 2 bubble cycles, then RUN.
  - Reset asserted during the LD_STALL cycle → outputs take reset values; after release, state is RUN and both counters read 0.
